btn_event_ctrl: RTL

- Debounce and event scheduler for the board push-buttons.
- Shares one tick prescaler across N button inputs and runs a small debounce/hold FSM per button.
- Arbitrates the resulting press, long-press and release events round-robin onto a single valid/ready event port.
- Consumers are the LED/counter logic and menu logic. They take one event at a time and never clock logic on a derived signal.

---
 rtl/btn_event_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/btn_event_ctrl.sv
// ============================================================================
// btn_event_ctrl
// ----------------------------------------------------------------------------
// Debounce and event scheduler for the board push-buttons.
//
// One shared tick prescaler drives N_BTN small debounce/hold FSMs. Each FSM
// raises press / long-press / release events into its own 1-deep pending
// slot. A round-robin arbiter moves pending events onto a single valid/ready
// event port.
//
// Ports:
//   clk        in   1       system clock
//   rst_n      in   1       asynchronous active-low reset
//   btn_in     in   N_BTN   raw asynchronous button levels, active high
//   ev_valid   out  1       event available
//   ev_ready   in   1       consumer accepts the event when ev_valid & ev_ready
//   ev_id      out  3       index of the button that raised the event
//   ev_type    out  2       01 press, 10 long, 11 release
//   btn_level  out  N_BTN   debounced level per button
//   overrun    out  N_BTN   sticky: an event was dropped for this button
//   ovr_clr    in   1       single-cycle pulse clearing all overrun bits
// ============================================================================
module btn_event_ctrl #(
    parameter int N_BTN      = 5,
    parameter int TICK_DIV   = 100000,
    parameter int DEB_TICKS  = 20,
    parameter int LONG_TICKS = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [2:0]       ev_id,
    output logic [1:0]       ev_type,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] overrun,
    input  logic             ovr_clr
);

    // ------------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------------
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // The per-button counter must hold LONG_TICKS itself (saturation value).
    localparam int CW = $clog2(LONG_TICKS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    // Counter comparisons are done one bit wider so cnt+1 never wraps.
    localparam logic [CW:0]   DEB_C     = (CW+1)'(DEB_TICKS);
    localparam logic [CW:0]   LONG_C    = (CW+1)'(LONG_TICKS);

    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_LONG    = 2'b10;
    localparam logic [1:0] EV_RELEASE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_P_BNC = 2'd1,
        ST_HELD  = 2'd2,
        ST_R_BNC = 2'd3
    } btn_state_t;

    // ------------------------------------------------------------------------
    // Input synchronizers: sync2_reg is the only view of the buttons used by
    // the rest of the block.
    // ------------------------------------------------------------------------
    logic [N_BTN-1:0] sync1_reg;
    logic [N_BTN-1:0] sync2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= btn_in;
            sync2_reg <= sync1_reg;
        end
    end

    // ------------------------------------------------------------------------
    // Shared sample-tick prescaler. tick is a clock enable, never a clock.
    // ------------------------------------------------------------------------
    logic [TW-1:0] tick_cnt_reg;
    logic [TW-1:0] tick_cnt_next;
    logic          tick;

    assign tick          = (tick_cnt_reg == TICK_LAST);
    assign tick_cnt_next = tick ? '0 : tick_cnt_reg + TW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // Signals shared between the per-button slices and the arbiter
    // ------------------------------------------------------------------------
    logic [N_BTN-1:0] pend_v;
    logic [1:0]       pend_t [N_BTN];
    logic [N_BTN-1:0] grant_vec;

    logic             grant_any;
    logic [2:0]       grant_idx;
    logic [1:0]       grant_type;

    // ------------------------------------------------------------------------
    // Per-button debounce/hold FSM and pending slot
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
            btn_state_t  state_reg;
            btn_state_t  state_next;
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;
            logic [CW:0]   cnt_inc;
            logic        long_done_reg;
            logic        long_done_next;
            logic        raise_c;
            logic [1:0]  raise_t_c;

            logic        pend_v_reg;
            logic        pend_v_next;
            logic [1:0]  pend_t_reg;
            logic [1:0]  pend_t_next;
            logic        ovr_reg;
            logic        ovr_next;

            assign cnt_inc = {1'b0, cnt_reg} + (CW+1)'(1);

            // One counter serves both bounce windows and the hold timer; its
            // meaning depends on the current state.
            always_comb begin
                state_next     = state_reg;
                cnt_next       = cnt_reg;
                long_done_next = long_done_reg;
                raise_c        = 1'b0;
                raise_t_c      = EV_PRESS;
                if (tick) begin
                    case (state_reg)
                        ST_IDLE: begin
                            if (sync2_reg[gi]) begin
                                state_next = ST_P_BNC;
                                cnt_next   = CW'(1);
                            end
                        end
                        ST_P_BNC: begin
                            if (!sync2_reg[gi]) begin
                                state_next = ST_IDLE;
                                cnt_next   = '0;
                            end else if (cnt_inc == DEB_C) begin
                                state_next     = ST_HELD;
                                cnt_next       = '0;
                                long_done_next = 1'b0;
                                raise_c        = 1'b1;
                                raise_t_c      = EV_PRESS;
                            end else begin
                                cnt_next = cnt_inc[CW-1:0];
                            end
                        end
                        ST_HELD: begin
                            if (sync2_reg[gi]) begin
                                // Saturate at LONG_TICKS so a very long hold
                                // never wraps back into another long event.
                                if (cnt_inc <= LONG_C) begin
                                    cnt_next = cnt_inc[CW-1:0];
                                end
                                if ((cnt_inc == LONG_C) && !long_done_reg) begin
                                    long_done_next = 1'b1;
                                    raise_c        = 1'b1;
                                    raise_t_c      = EV_LONG;
                                end
                            end else begin
                                state_next = ST_R_BNC;
                                cnt_next   = CW'(1);
                            end
                        end
                        ST_R_BNC: begin
                            if (sync2_reg[gi]) begin
                                // Bounce back into the hold: long_done is kept
                                // so a glitch cannot cause a second long event.
                                state_next = ST_HELD;
                                cnt_next   = '0;
                            end else if (cnt_inc == DEB_C) begin
                                state_next = ST_IDLE;
                                cnt_next   = '0;
                                raise_c    = 1'b1;
                                raise_t_c  = EV_RELEASE;
                            end else begin
                                cnt_next = cnt_inc[CW-1:0];
                            end
                        end
                        default: begin
                            state_next = ST_IDLE;
                            cnt_next   = '0;
                        end
                    endcase
                end
            end

            // Pending slot: a grant frees the slot in the same cycle, so a new
            // event arriving alongside a grant is stored rather than dropped.
            always_comb begin
                pend_v_next = pend_v_reg;
                pend_t_next = pend_t_reg;
                ovr_next    = ovr_clr ? 1'b0 : ovr_reg;
                if (grant_vec[gi]) begin
                    pend_v_next = 1'b0;
                end
                if (raise_c) begin
                    if (pend_v_reg && !grant_vec[gi]) begin
                        // New overrun wins over a coincident clear.
                        ovr_next = 1'b1;
                    end else begin
                        pend_v_next = 1'b1;
                        pend_t_next = raise_t_c;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg     <= ST_IDLE;
                    cnt_reg       <= '0;
                    long_done_reg <= 1'b0;
                    pend_v_reg    <= 1'b0;
                    pend_t_reg    <= 2'b00;
                    ovr_reg       <= 1'b0;
                end else begin
                    state_reg     <= state_next;
                    cnt_reg       <= cnt_next;
                    long_done_reg <= long_done_next;
                    pend_v_reg    <= pend_v_next;
                    pend_t_reg    <= pend_t_next;
                    ovr_reg       <= ovr_next;
                end
            end

            assign pend_v[gi]    = pend_v_reg;
            assign pend_t[gi]    = pend_t_reg;
            assign overrun[gi]   = ovr_reg;
            assign btn_level[gi] = (state_reg == ST_HELD) || (state_reg == ST_R_BNC);
            assign grant_vec[gi] = grant_any && (grant_idx == 3'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Round-robin arbiter and output register
    // ------------------------------------------------------------------------
    logic       ev_valid_reg;
    logic       ev_valid_next;
    logic [2:0] ev_id_reg;
    logic [2:0] ev_id_next;
    logic [1:0] ev_type_reg;
    logic [1:0] ev_type_next;
    logic [2:0] ptr_reg;
    logic [2:0] ptr_next;
    logic       slot_free;

    logic       found_hi;
    logic       found_lo;
    logic [2:0] idx_hi;
    logic [2:0] idx_lo;
    logic [1:0] type_hi;
    logic [1:0] type_lo;

    assign slot_free = !ev_valid_reg || ev_ready;

    // Search order ptr+1 .. N_BTN-1, then wrap to 0 .. ptr. Splitting the
    // scan into "above ptr" and "at/below ptr" avoids any modulo arithmetic.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        type_hi  = '0;
        type_lo  = '0;
        for (int j = 0; j < N_BTN; j++) begin
            if (pend_v[j]) begin
                if (3'(j) > ptr_reg) begin
                    if (!found_hi) begin
                        found_hi = 1'b1;
                        idx_hi   = 3'(j);
                        type_hi  = pend_t[j];
                    end
                end else if (!found_lo) begin
                    found_lo = 1'b1;
                    idx_lo   = 3'(j);
                    type_lo  = pend_t[j];
                end
            end
        end
        grant_any  = slot_free && (found_hi || found_lo);
        grant_idx  = found_hi ? idx_hi  : idx_lo;
        grant_type = found_hi ? type_hi : type_lo;
    end

    // ev_id / ev_type only change when a new grant is loaded, so they stay
    // stable for as long as the consumer stalls.
    always_comb begin
        ev_valid_next = ev_valid_reg;
        ev_id_next    = ev_id_reg;
        ev_type_next  = ev_type_reg;
        ptr_next      = ptr_reg;
        if (slot_free) begin
            ev_valid_next = grant_any;
            if (grant_any) begin
                ev_id_next   = grant_idx;
                ev_type_next = grant_type;
                ptr_next     = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_valid_reg <= 1'b0;
            ev_id_reg    <= '0;
            ev_type_reg  <= '0;
            ptr_reg      <= '0;
        end else begin
            ev_valid_reg <= ev_valid_next;
            ev_id_reg    <= ev_id_next;
            ev_type_reg  <= ev_type_next;
            ptr_reg      <= ptr_next;
        end
    end

    assign ev_valid = ev_valid_reg;
    assign ev_id    = ev_id_reg;
    assign ev_type  = ev_type_reg;

endmodule
